rl_ras_err_log: RTL and testbench

RL_RAS_ERR_LOG -- requirements
Module: rl_ras_err_log

---
 rtl/rl_ras_err_log_pkg.sv | 35 +++
 rtl/rl_ras_log_fifo.sv | 59 +++++
 rtl/rl_ras_err_log.sv | 124 ++++++++++++
 tb/tb_rl_ras_err_log.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rl_ras_err_log_pkg.sv
// Shared RAS defines: ECC widths, error source ids, log entry type encoding.
package rl_ras_err_log_pkg;

  localparam int RAS_ECC_SYND_W = 8;
  localparam int RAS_ECC_ADDR_W = 20;

  localparam int NUM_SRC = 5;
  localparam int SRC_W   = 3;
  localparam int TYPE_W  = 2;

  localparam logic [SRC_W-1:0] SRC_ICCM0   = 3'd0;
  localparam logic [SRC_W-1:0] SRC_DCCM_EV = 3'd1;
  localparam logic [SRC_W-1:0] SRC_DCCM_OD = 3'd2;
  localparam logic [SRC_W-1:0] SRC_IC_TAG  = 3'd3;
  localparam logic [SRC_W-1:0] SRC_IC_DATA = 3'd4;

  typedef enum logic [TYPE_W-1:0] {
    RAS_T_NONE = 2'b00,
    RAS_T_SB   = 2'b01,
    RAS_T_DB   = 2'b10,
    RAS_T_ADDR = 2'b11
  } ras_type_e;

  // Address errors outrank double-bit, which outrank single-bit.
  function automatic ras_type_e ras_type_f(input logic addr_err, input logic db_err);
    if (addr_err)    return RAS_T_ADDR;
    else if (db_err) return RAS_T_DB;
    else             return RAS_T_SB;
  endfunction

  function automatic logic [SRC_W-1:0] ras_next_src(input logic [SRC_W-1:0] s);
    return (s == SRC_W'(NUM_SRC - 1)) ? '0 : s + SRC_W'(1);
  endfunction

endpackage

// File: rtl/rl_ras_log_fifo.sv
// Small synchronous FIFO for RAS log entries; head is masked to zero when empty.
module rl_ras_log_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_a,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & valid_o;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;

  always_comb begin
    wr_d  = push_ok ? wr_q + PTR_W'(1) : wr_q;
    rd_d  = pop_ok  ? rd_q + PTR_W'(1) : rd_q;
    cnt_d = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/rl_ras_err_log.sv
// RAS error logger: per-source holding registers, round-robin drain into a log FIFO.
module rl_ras_err_log
  import rl_ras_err_log_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SYND_W = RAS_ECC_SYND_W,
  parameter int ADDR_W = RAS_ECC_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst_a,
  input  logic [NUM_SRC-1:0]          src_addr_err,
  input  logic [NUM_SRC-1:0]          src_sb_err,
  input  logic [NUM_SRC-1:0]          src_db_err,
  input  logic [NUM_SRC*SYND_W-1:0]   src_synd,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
  output logic                        log_valid,
  input  logic                        log_ready,
  output logic [SRC_W-1:0]            log_src,
  output logic [TYPE_W-1:0]           log_type,
  output logic [SYND_W-1:0]           log_synd,
  output logic [ADDR_W-1:0]           log_addr,
  output logic [$clog2(DEPTH):0]      log_count,
  output logic                        log_ovf,
  input  logic                        ovf_clr,
  output logic                        hp_err
);

  localparam int ENT_W = SRC_W + TYPE_W + SYND_W + ADDR_W;

  logic [NUM_SRC-1:0] pend_q, pend_d, load, ev;
  ras_type_e          type_q [NUM_SRC];
  logic [SYND_W-1:0]  synd_q [NUM_SRC];
  logic [ADDR_W-1:0]  addr_q [NUM_SRC];
  logic [SRC_W-1:0]   rr_q, rr_d, win, cand;
  logic               win_vld, push, fifo_full, drop;
  logic               ovf_q, ovf_d, hp_q, hp_d;
  logic [ENT_W-1:0]   push_data, head_data;

  assign ev = src_addr_err | src_sb_err | src_db_err;

  // Round-robin search starting at rr_q; only the registered full flag gates the push.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = SRC_W'((int'(rr_q) + k) % NUM_SRC);
      if (!win_vld && pend_q[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
    push = win_vld & ~fifo_full;
    rr_d = push ? ras_next_src(win) : rr_q;
  end

  // A new event may replace an entry only when that entry is draining this cycle.
  always_comb begin
    pend_d = pend_q;
    load   = '0;
    drop   = 1'b0;
    hp_d   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ev[i]) begin
        if (src_addr_err[i] || src_db_err[i]) hp_d = 1'b1;
        if (!pend_q[i] || (push && win == SRC_W'(i))) begin
          pend_d[i] = 1'b1;
          load[i]   = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else if (push && win == SRC_W'(i)) begin
        pend_d[i] = 1'b0;
      end
    end
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      pend_q <= '0;
      rr_q   <= '0;
      ovf_q  <= 1'b0;
      hp_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      rr_q   <= rr_d;
      ovf_q  <= ovf_d;
      hp_q   <= hp_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (load[i]) begin
        type_q[i] <= ras_type_f(src_addr_err[i], src_db_err[i]);
        synd_q[i] <= src_synd[i*SYND_W +: SYND_W];
        addr_q[i] <= src_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign push_data = {win, type_q[win], synd_q[win], addr_q[win]};

  rl_ras_log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_a   (rst_a),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (log_ready),
    .valid_o (log_valid),
    .data_o  (head_data),
    .count_o (log_count),
    .full_o  (fifo_full)
  );

  assign {log_src, log_type, log_synd, log_addr} = head_data;
  assign log_ovf = ovf_q;
  assign hp_err  = hp_q;

endmodule

// File: tb/tb_rl_ras_err_log.sv
// Bench for rl_ras_err_log: directed scenarios plus random traffic against a queue-based model.
module tb_rl_ras_err_log;

  localparam int DEPTH  = 4;
  localparam int SYND_W = 8;
  localparam int ADDR_W = 20;
  localparam int NS     = 5;

  logic                     clk = 1'b0;
  logic                     rst_a = 1'b1;
  logic [NS-1:0]            src_addr_err = '0, src_sb_err = '0, src_db_err = '0;
  logic [NS*SYND_W-1:0]     src_synd = '0;
  logic [NS*ADDR_W-1:0]     src_addr = '0;
  logic                     log_valid, log_ready = 1'b0, log_ovf, ovf_clr = 1'b0, hp_err;
  logic [2:0]               log_src;
  logic [1:0]               log_type;
  logic [SYND_W-1:0]        log_synd;
  logic [ADDR_W-1:0]        log_addr;
  logic [$clog2(DEPTH):0]   log_count;

  always #5 clk = ~clk;

  rl_ras_err_log #(.DEPTH(DEPTH), .SYND_W(SYND_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_a(rst_a),
    .src_addr_err(src_addr_err), .src_sb_err(src_sb_err), .src_db_err(src_db_err),
    .src_synd(src_synd), .src_addr(src_addr),
    .log_valid(log_valid), .log_ready(log_ready),
    .log_src(log_src), .log_type(log_type), .log_synd(log_synd), .log_addr(log_addr),
    .log_count(log_count), .log_ovf(log_ovf), .ovf_clr(ovf_clr), .hp_err(hp_err)
  );

  typedef struct packed {
    logic [2:0]        src;
    logic [1:0]        typ;
    logic [SYND_W-1:0] synd;
    logic [ADDR_W-1:0] addr;
  } ent_t;

  ent_t mq[$];
  ent_t mhold[NS];
  bit   mpend[NS];
  int   mrr;
  bit   movf, mhp;
  int   n_checks = 0, n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NS; i++) mpend[i] = 1'b0;
    mrr  = 0;
    movf = 1'b0;
    mhp  = 1'b0;
  endtask

  // One clock edge of the logger, from the rules: one transfer per non-full cycle, drops only when the slot stays busy.
  task automatic model_step();
    int win, idx;
    bit full, set_ovf, hp;
    full = (mq.size() == DEPTH);
    win  = -1;
    if (!full)
      for (int k = 0; k < NS; k++) begin
        idx = (mrr + k) % NS;
        if (win < 0 && mpend[idx]) win = idx;
      end
    if (mq.size() != 0 && log_ready) void'(mq.pop_front());
    if (win >= 0) begin
      mq.push_back(mhold[win]);
      mrr = (win + 1) % NS;
    end
    set_ovf = 1'b0;
    hp      = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (src_addr_err[i] || src_sb_err[i] || src_db_err[i]) begin
        if (src_addr_err[i] || src_db_err[i]) hp = 1'b1;
        if (!mpend[i] || win == i) begin
          mpend[i]       = 1'b1;
          mhold[i].src   = 3'(i);
          mhold[i].typ   = src_addr_err[i] ? 2'd3 : (src_db_err[i] ? 2'd2 : 2'd1);
          mhold[i].synd  = src_synd[i*SYND_W +: SYND_W];
          mhold[i].addr  = src_addr[i*ADDR_W +: ADDR_W];
        end else begin
          set_ovf = 1'b1;
        end
      end else if (win == i) begin
        mpend[i] = 1'b0;
      end
    end
    movf = set_ovf ? 1'b1 : (ovf_clr ? 1'b0 : movf);
    mhp  = hp;
  endtask

  task automatic check_outputs();
    ent_t h;
    h = '0;
    if (mq.size() != 0) h = mq[0];
    check_val("valid", log_valid, mq.size() != 0);
    check_val("count", log_count, mq.size());
    check_val("src",   log_src,   h.src);
    check_val("type",  log_type,  h.typ);
    check_val("synd",  log_synd,  h.synd);
    check_val("addr",  log_addr,  h.addr);
    check_val("ovf",   log_ovf,   movf);
    check_val("hp",    hp_err,    mhp);
  endtask

  task automatic step(input logic [NS-1:0] a, input logic [NS-1:0] s, input logic [NS-1:0] d,
                      input logic rdy, input logic clr);
    src_addr_err = a;
    src_sb_err   = s;
    src_db_err   = d;
    log_ready    = rdy;
    ovf_clr      = clr;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    src_addr_err = '0;
    src_sb_err   = '0;
    src_db_err   = '0;
    ovf_clr      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_a = 1'b0;
    #2;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < NS; i++) begin
      src_synd[i*SYND_W +: SYND_W] = SYND_W'($urandom);
      src_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    end
  endtask

  logic [NS-1:0] ra, rs, rd;
  logic [2:0]    exp_src;

  initial begin
    do_reset();

    // Single SB on source 1
    src_synd[1*SYND_W +: SYND_W] = 8'h5A;
    src_addr[1*ADDR_W +: ADDR_W] = 20'h00123;
    step('0, 5'b00010, '0, 1'b1, 1'b0);
    check_val("s1_valid_n1", log_valid, 1'b0);
    step('0, '0, '0, 1'b1, 1'b0);
    check_val("s1_valid_n2", log_valid, 1'b1);
    check_val("s1_src",  log_src,  3'd1);
    check_val("s1_type", log_type, 2'b01);
    check_val("s1_synd", log_synd, 8'h5A);
    check_val("s1_addr", log_addr, 20'h00123);
    check_val("s1_hp",   hp_err,   1'b0);
    step('0, '0, '0, 1'b1, 1'b0);

    // All five sources DB at once, consumer stalled
    do_reset();
    rand_lanes();
    step('0, '0, 5'h1f, 1'b0, 1'b0);
    check_val("s2_hp_pulse", hp_err, 1'b1);
    step('0, '0, '0, 1'b0, 1'b0);
    check_val("s2_hp_once", hp_err, 1'b0);
    repeat (4) step('0, '0, '0, 1'b0, 1'b0);
    check_val("s2_count_full", log_count, 4);
    check_val("s2_head0", log_src, 3'd0);
    step('0, '0, '0, 1'b1, 1'b0);
    check_val("s2_count_pop", log_count, 3);
    step('0, '0, '0, 1'b0, 1'b0);
    check_val("s2_src4_admit", log_count, 4);
    for (int k = 1; k <= 4; k++) begin
      exp_src = 3'(k);
      check_val("s2_order", log_src, exp_src);
      step('0, '0, '0, 1'b1, 1'b0);
    end

    // ADDR and SB together on source 3
    rand_lanes();
    step(5'b01000, 5'b01000, '0, 1'b0, 1'b0);
    step('0, '0, '0, 1'b0, 1'b0);
    check_val("s3_src", log_src, 3'd3);
    check_val("s3_type", log_type, 2'b11);
    step('0, '0, '0, 1'b1, 1'b0);

    // Overflow on source 0 while the FIFO is full
    do_reset();
    rand_lanes();
    step('0, 5'b11110, '0, 1'b0, 1'b0);
    repeat (4) step('0, '0, '0, 1'b0, 1'b0);
    check_val("s4_full", log_count, 4);
    step('0, 5'b00001, '0, 1'b0, 1'b0);
    check_val("s4_no_ovf_yet", log_ovf, 1'b0);
    step('0, 5'b00001, '0, 1'b0, 1'b0);
    check_val("s4_ovf_set", log_ovf, 1'b1);
    step('0, 5'b00001, '0, 1'b0, 1'b1);
    check_val("s4_set_wins", log_ovf, 1'b1);
    step('0, '0, '0, 1'b0, 1'b1);
    check_val("s4_ovf_clr", log_ovf, 1'b0);
    repeat (6) step('0, '0, '0, 1'b1, 1'b0);

    // Sources 2 and 4 take turns every cycle under continuous pop
    do_reset();
    exp_src = 3'd2;
    for (int c = 0; c < 20; c++) begin
      rand_lanes();
      step('0, (c % 2 == 0) ? 5'b00100 : 5'b10000, '0, 1'b1, 1'b0);
      if (log_valid) begin
        check_val("s5_alt", log_src, exp_src);
        exp_src = (exp_src == 3'd2) ? 3'd4 : 3'd2;
      end
    end
    check_val("s5_ovf", log_ovf, 1'b0);
    repeat (3) step('0, '0, '0, 1'b1, 1'b0);

    // Reset in the middle of operation with three logged entries
    do_reset();
    rand_lanes();
    step('0, 5'b00111, '0, 1'b0, 1'b0);
    repeat (3) step('0, '0, '0, 1'b0, 1'b0);
    check_val("s6_count3", log_count, 3);
    #2;
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    check_val("s6_valid", log_valid, 1'b0);
    check_val("s6_count", log_count, 0);
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_a = 1'b1;

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      rand_lanes();
      for (int i = 0; i < NS; i++) begin
        ra[i] = ($urandom_range(0, 15) == 0);
        rs[i] = ($urandom_range(0, 5) == 0);
        rd[i] = ($urandom_range(0, 11) == 0);
      end
      step(ra, rs, rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
